// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch_unit and imem
interface fetch_unit_if #(
  parameter int XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction register and imem fetch handshake
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            i_PCWrite,
  input  logic            i_PCWriteCond,
  input  logic            i_PCSrc,
  input  logic [1:0]      i_BranchOp,
  input  logic            i_LoadIR,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic            i_alu_zero,
  input  logic            i_alu_lt,
  output logic [31:0]     o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic            o_fetch_busy,
  output logic            o_instr_valid,
  output logic            o_fetch_err,
  output logic            o_misalign_err
);

  localparam int          CW  = $clog2(TIMEOUT + 1);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [31:0]     r_instr;
  logic            r_req;
  logic            r_busy;
  logic            r_valid;
  logic            r_ferr;
  logic            r_merr;

  logic            w_take;
  logic            w_pc_we;
  logic [XLEN-1:0] w_next_pc;

  always_comb begin
    w_take = 1'b0;
    case (i_BranchOp)
      2'b00:   w_take = i_alu_zero;
      2'b01:   w_take = !i_alu_zero;
      2'b10:   w_take = !i_alu_lt;
      default: w_take = i_alu_lt;
    endcase
  end

  assign w_pc_we   = i_PCWrite | (i_PCWriteCond & w_take);
  assign w_next_pc = i_PCSrc ? i_alu_out : i_alu_result;

  // A misaligned target is dropped rather than written, so pc always stays word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_merr <= 1'b0;
    end else if (w_pc_we) begin
      if (w_next_pc[1:0] != 2'b00) r_merr <= 1'b1;
      else                         r_pc   <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_instr <= NOP;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_LoadIR) begin
            r_addr  <= r_pc;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        default: begin
          if (imem.imem_ack) begin
            r_instr <= imem.imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_instr <= NOP;
            r_valid <= 1'b1;
            r_ferr  <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign o_instruction  = r_instr;
  assign o_pc           = r_pc;
  assign o_fetch_busy   = r_busy;
  assign o_instr_valid  = r_valid;
  assign o_fetch_err    = r_ferr;
  assign o_misalign_err = r_merr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a cycle-level reference model
module tb_fetch_unit;
  localparam int          XLEN = 64;
  localparam int          TO   = 15;
  localparam logic [31:0] NOP  = 32'h00000013;

  typedef struct {
    logic            pcwc;
    logic            src;
    logic [1:0]      op;
    logic            z;
    logic            lt;
    logic [XLEN-1:0] exp_pc;
  } br_vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pc_write = 1'b0, pc_write_cond = 1'b0, pc_src = 1'b0, load_ir = 1'b0;
  logic [1:0]      branch_op = 2'b00;
  logic [XLEN-1:0] alu_result = '0, alu_out = '0;
  logic            alu_zero = 1'b0, alu_lt = 1'b0;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            fetch_busy, instr_valid, fetch_err, misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [XLEN-1:0] m_pc = '0, m_addr = '0;
  logic [31:0]     m_instr = NOP;
  logic            m_req = 1'b0, m_valid = 1'b0, m_ferr = 1'b0, m_merr = 1'b0;
  int              m_age = 0;

  br_vec_t br_tbl[10];

  fetch_unit_if #(.XLEN(XLEN)) imem_bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC('0), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus),
    .i_PCWrite      (pc_write),
    .i_PCWriteCond  (pc_write_cond),
    .i_PCSrc        (pc_src),
    .i_BranchOp     (branch_op),
    .i_LoadIR       (load_ir),
    .i_alu_result   (alu_result),
    .i_alu_out      (alu_out),
    .i_alu_zero     (alu_zero),
    .i_alu_lt       (alu_lt),
    .o_instruction  (instruction),
    .o_pc           (pc),
    .o_fetch_busy   (fetch_busy),
    .o_instr_valid  (instr_valid),
    .o_fetch_err    (fetch_err),
    .o_misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_addr = '0; m_instr = NOP; m_req = 1'b0;
    m_valid = 1'b0; m_ferr = 1'b0; m_merr = 1'b0; m_age = 0;
  endtask

  // Next state from the rules: branch table lookup, fetch age measured in edges since launch.
  task automatic model_step();
    bit [3:0]        takes;
    bit              we;
    logic [XLEN-1:0] tgt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    takes = {alu_lt, !alu_lt, !alu_zero, alu_zero};
    we    = pc_write || (pc_write_cond && takes[branch_op]);
    tgt   = pc_src ? alu_out : alu_result;
    m_valid = 1'b0;
    if (m_req) begin
      m_age++;
      if (imem_bus.imem_ack) begin
        m_instr = imem_bus.imem_rdata; m_valid = 1'b1; m_req = 1'b0;
      end else if (m_age > TO) begin
        m_instr = NOP; m_valid = 1'b1; m_ferr = 1'b1; m_req = 1'b0;
      end
    end else if (load_ir) begin
      m_req = 1'b1; m_addr = m_pc; m_age = 0;
    end
    if (we) begin
      if (tgt % 4 != 0) m_merr = 1'b1;
      else              m_pc   = tgt;
    end
  endtask

  task automatic chk_model();
    chk("m_pc", pc, m_pc);
    chk("m_instr", {32'd0, instruction}, {32'd0, m_instr});
    chk("m_req", {63'd0, imem_bus.imem_req}, {63'd0, m_req});
    chk("m_addr", imem_bus.imem_addr, m_addr);
    chk("m_busy", {63'd0, fetch_busy}, {63'd0, m_req});
    chk("m_valid", {63'd0, instr_valid}, {63'd0, m_valid});
    chk("m_ferr", {63'd0, fetch_err}, {63'd0, m_ferr});
    chk("m_merr", {63'd0, misalign_err}, {63'd0, m_merr});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic clear_ctl();
    pc_write = 1'b0; pc_write_cond = 1'b0; pc_src = 1'b0; load_ir = 1'b0;
    branch_op = 2'b00; alu_zero = 1'b0; alu_lt = 1'b0;
  endtask

  initial begin
    int nb;
    int nv;
    br_tbl[0] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 64'h40};
    br_tbl[1] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 64'h10};
    br_tbl[2] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 64'h10};
    br_tbl[3] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 64'h40};
    br_tbl[4] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 64'h10};
    br_tbl[5] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 64'h40};
    br_tbl[6] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 64'h40};
    br_tbl[7] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 64'h10};
    br_tbl[8] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 64'h10};
    br_tbl[9] = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 64'h80};

    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;

    // reset state
    tick(); tick();
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", {32'd0, instruction}, {32'd0, NOP});
    chk("rst_req", {63'd0, imem_bus.imem_req}, 64'd0);
    chk("rst_addr", imem_bus.imem_addr, 64'h0);
    chk("rst_flags", {60'd0, fetch_busy, instr_valid, fetch_err, misalign_err}, 64'd0);
    rst_n = 1'b1;

    // first fetch with simultaneous PC write, ack after three busy cycles
    load_ir = 1'b1; pc_write = 1'b1; alu_result = 64'h4;
    tick();
    clear_ctl();
    chk("f1_addr", imem_bus.imem_addr, 64'h0);
    chk("f1_pc", pc, 64'h4);
    nb = fetch_busy; nv = instr_valid;
    tick(); nb += fetch_busy; nv += instr_valid;
    tick(); nb += fetch_busy; nv += instr_valid;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h00A00093;
    tick(); nb += fetch_busy; nv += instr_valid;
    chk("f1_instr", {32'd0, instruction}, 64'h00A00093);
    chk("f1_valid", {63'd0, instr_valid}, 64'd1);
    imem_bus.imem_ack = 1'b0;
    tick(); nb += fetch_busy; nv += instr_valid;
    chk("f1_busy_cycles", nb, 3);
    chk("f1_valid_pulses", nv, 1);

    // branch table
    for (int i = 0; i < 10; i++) begin
      pc_write = 1'b1; alu_result = 64'h10;
      tick();
      pc_write = 1'b0;
      chk("br_pre_pc", pc, 64'h10);
      pc_write_cond = br_tbl[i].pcwc; pc_src = br_tbl[i].src; branch_op = br_tbl[i].op;
      alu_zero = br_tbl[i].z; alu_lt = br_tbl[i].lt;
      alu_result = 64'h80; alu_out = 64'h40;
      tick();
      chk($sformatf("br_row%0d_pc", i), pc, br_tbl[i].exp_pc);
      clear_ctl();
    end

    // misaligned write is dropped, sticky flag set, concurrent fetch still launches
    pc_write = 1'b1; alu_result = 64'h6; load_ir = 1'b1;
    tick();
    clear_ctl();
    chk("mis_pc", pc, 64'h80);
    chk("mis_flag", {63'd0, misalign_err}, 64'd1);
    chk("mis_fetch_addr", {imem_bus.imem_addr[62:0], imem_bus.imem_req}, {63'h80, 1'b1});
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h11111111;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk("mis_fetch_instr", {32'd0, instruction}, 64'h11111111);
    tick(); tick(); tick();
    chk("mis_sticky", {63'd0, misalign_err}, 64'd1);

    // timeout
    load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
    nb = fetch_busy;
    for (int i = 0; i < TO; i++) begin
      tick(); nb += fetch_busy;
    end
    tick();
    chk("to_busy_cycles", nb, TO + 1);
    chk("to_instr", {32'd0, instruction}, {32'd0, NOP});
    chk("to_valid_err", {62'd0, instr_valid, fetch_err}, 64'd3);
    chk("to_busy_after", {63'd0, fetch_busy}, 64'd0);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEADBEEF;
    tick();
    imem_bus.imem_ack = 1'b0;
    chk("late_ack_instr", {32'd0, instruction}, {32'd0, NOP});
    chk("late_ack_valid_req", {62'd0, instr_valid, imem_bus.imem_req}, 64'd0);

    // LoadIR ignored mid-BUSY, then async reset aborts
    load_ir = 1'b1;
    tick();
    chk("ign_addr0", imem_bus.imem_addr, 64'h80);
    pc_write = 1'b1; alu_result = 64'h100;
    tick();
    pc_write = 1'b0;
    chk("ign_addr1", imem_bus.imem_addr, 64'h80);
    chk("ign_pc", pc, 64'h100);
    tick();
    load_ir = 1'b0;
    chk("ign_addr2", imem_bus.imem_addr, 64'h80);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_req", {63'd0, imem_bus.imem_req}, 64'd0);
    chk("abort_pc", pc, 64'h0);
    chk("abort_sticky", {62'd0, fetch_err, misalign_err}, 64'd0);
    chk_model();
    tick();
    rst_n = 1'b1;

    // back-to-back: ack with PC write, then a new fetch on the next edge
    load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
    chk("b2b_addr0", imem_bus.imem_addr, 64'h0);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h00100113;
    pc_write = 1'b1; alu_result = 64'h8;
    tick();
    nv = instr_valid;
    imem_bus.imem_ack = 1'b0; pc_write = 1'b0; load_ir = 1'b1;
    tick();
    nv += instr_valid;
    load_ir = 1'b0;
    chk("b2b_addr1", {imem_bus.imem_addr[62:0], imem_bus.imem_req}, {63'h8, 1'b1});
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h00200193;
    tick();
    nv += instr_valid;
    imem_bus.imem_ack = 1'b0;
    chk("b2b_instr", {32'd0, instruction}, 64'h00200193);
    tick();
    nv += instr_valid;
    chk("b2b_valid_pulses", nv, 2);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      pc_write      = ($urandom_range(3, 0) == 0);
      pc_write_cond = ($urandom_range(3, 0) == 0);
      pc_src        = $urandom_range(1, 0);
      branch_op     = 2'($urandom_range(3, 0));
      alu_zero      = $urandom_range(1, 0);
      alu_lt        = $urandom_range(1, 0);
      load_ir       = ($urandom_range(2, 0) == 0);
      alu_result    = {$urandom, $urandom};
      alu_out       = {$urandom, $urandom};
      if ($urandom_range(15, 0) != 0) alu_result[1:0] = 2'b00;
      if ($urandom_range(15, 0) != 0) alu_out[1:0] = 2'b00;
      imem_bus.imem_ack   = ($urandom_range(5, 0) == 0);
      imem_bus.imem_rdata = $urandom;
      tick();
    end
    clear_ctl();
    imem_bus.imem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC stage that sits directly upstream of `unidadeControle`. It owns the program counter and instruction register, and performs the handshake with instruction memory. It resolves conditional PC writes from the control unit's `PCWrite`/`PCWriteCond`/`BranchOp`/`PCSrc` outputs and the ALU flags. It supplies `instruction` to the control unit and datapath, and stalls the control unit while a fetch is outstanding.

## Interface
- `XLEN`, 64: PC and datapath width.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: maximum wait cycles for `imem_ack` before the fetch is aborted (≥1).
- `clk` in 1: single clock, all state updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCWrite` in 1: unconditional PC write from control unit.
- `PCWriteCond` in 1: conditional PC write (branch states).
- `PCSrc` in 1: 0 = `alu_result` (PC+4), 1 = `alu_out` (branch target held in ALUOut).
- `BranchOp` in 2: 00 BEQ, 01 BNE, 10 BGE, 11 BLT.
- `LoadIR` in 1: start instruction fetch.
- `alu_result` in XLEN: live ALU output.
- `alu_out` in XLEN: ALUOut register.
- `alu_zero` in 1: ALU result == 0.
- `alu_lt` in 1: signed A < B from the subtract.
- `imem_req` out 1: fetch request, held until acked.
- `imem_addr` out XLEN: fetch address, stable while `imem_req`=1.
- `imem_ack` in 1: memory data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instruction` out 32: instruction register.
- `pc` out XLEN: program counter.
- `fetch_busy` out 1: fetch outstanding; the control unit holds its state while this is 1.
- `instr_valid` out 1: one-cycle pulse when `instruction` is newly loaded.
- `fetch_err` out 1: sticky, set on timeout.
- `misalign_err` out 1: sticky, set when a PC write targets an address with `[1:0]≠0`.

## Operation
- PC write enable:
  - `take` is selected by `BranchOp`: 00 `alu_zero`; 01 `!alu_zero`; 10 `!alu_lt`; 11 `alu_lt`.
  - `pc_we = PCWrite | (PCWriteCond & take)`.
  - `next_pc = PCSrc ? alu_out : alu_result`.
- If `pc_we` and `next_pc[1:0]≠0`: PC is not written, and `misalign_err` is set. The fetch still proceeds if `LoadIR` is also asserted.
- Fetch FSM states:
  - IDLE: on `LoadIR`=1, latch the current `pc` (the value before any same-cycle PC write) into `imem_addr`, clear the wait counter, and go to BUSY.
  - BUSY: `imem_req`=1 and `fetch_busy`=1.
    - On `imem_ack`: load `instruction <= imem_rdata`, pulse `instr_valid`, go to IDLE.
    - If no ack and the counter reaches `TIMEOUT`: load `instruction <= 32'h00000013` (NOP), pulse `instr_valid`, set `fetch_err`, go to IDLE.
    - Otherwise increment the counter (width `$clog2(TIMEOUT+1)`, saturating).
- `LoadIR` in BUSY is ignored and does not restart the fetch.
- `imem_ack` in IDLE is ignored, so a late ack after a timeout or reset has no effect.
- PC updates are independent of the FSM: `pc_we` is honoured in any state.
- Sticky errors clear only on reset.

## Timing
- Reset (async, immediate):
  - `pc`=`RESET_PC`; `instruction`=32'h00000013.
  - `imem_req`=0; `imem_addr`=0; `fetch_busy`=0; `instr_valid`=0.
  - `fetch_err`=0; `misalign_err`=0; FSM in IDLE; counter 0.
- Reset during BUSY aborts the fetch, and `imem_req` drops immediately.
- All outputs are registered. No combinational path from any input to any output.
- PC: `pc_we` sampled at edge N → new `pc` visible after edge N.
- Fetch, with `LoadIR` sampled at edge N:
  - `imem_req`/`imem_addr` valid after N.
  - Ack sampled at edge M≥N+1 → `instruction` updated, `instr_valid`=1, and `fetch_busy`=0 for the cycle after M.
  - Minimum fetch latency is 1 cycle (ack in the first req cycle).
- Timeout: the counter is 0 in the first BUSY cycle. With no ack, the abort happens at edge N+TIMEOUT+1.
- Simultaneous `LoadIR` and `PCWrite` at edge N: `imem_addr` = old PC, and `pc` = old PC+4 after N.

## Test plan
- **Reset/fetch:** release `rst_n`, pulse `LoadIR` with `PCWrite`=1 and `alu_result`=4, ack after 3 cycles with 0x00A00093. Required: `imem_addr`=0; `pc`=4; `instruction`=0x00A00093 with one `instr_valid` pulse; `fetch_busy` high for exactly 3 cycles.
- **Branches:** with `PCWriteCond`=1, `PCSrc`=1, `alu_out`=0x40, step `BranchOp` 00..11 against flags (zero,lt) = (1,0), (1,0), (0,1), (0,1). Required: PC written to 0x40 only for BEQ and BLT.
- **Misalign:** `PCWrite`=1, `alu_result`=0x6. Required: `pc` unchanged; `misalign_err`=1 and stays 1 until reset.
- **Timeout:** `TIMEOUT`=15, `LoadIR`, never ack. Required: after 16 BUSY cycles `instruction`=0x00000013 and `fetch_err`=1. A later ack in IDLE changes nothing.
- **Ignore/abort:** `LoadIR` re-asserted mid-BUSY keeps `imem_addr` stable. Asserting `rst_n`=0 mid-BUSY drops `imem_req` the same cycle, `pc`=`RESET_PC`.
- **Back-to-back:** ack and a new `LoadIR` on consecutive edges. Required: second fetch addresses the updated PC, with no lost `instr_valid` pulse.
